// File: rtl/sha2_digest_collector_if.sv
// rtl/sha2_digest_collector_if.sv - word input and byte output signals of the digest collector
interface sha2_digest_collector_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8
);
  logic                    in_valid;
  logic [WORD_W-1:0]       in_word;
  logic                    flush;
  logic [WORD_W*WORDS-1:0] digest;
  logic                    digest_valid;
  logic [7:0]              out_byte;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overflow;

  modport master (
    output in_valid, in_word, flush, out_ready,
    input  digest, digest_valid, out_byte, out_valid, overflow
  );

  modport slave (
    input  in_valid, in_word, flush, out_ready,
    output digest, digest_valid, out_byte, out_valid, overflow
  );
endinterface

// File: rtl/sha2_digest_collector.sv
// rtl/sha2_digest_collector.sv - gathers SHA-256 digest words, presents them in parallel
// and streams the digest byte-serially MSB first.
module sha2_digest_collector #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8
) (
  input logic                    clk,
  input logic                    rst,
  sha2_digest_collector_if.slave bus
);
  localparam int DIG_W  = WORD_W * WORDS;
  localparam int NBYTES = DIG_W / 8;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NBYTES - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [BCNT_W-1:0] bcnt;
  logic [DIG_W-1:0]  digest_q;
  logic              dvalid_q;
  logic              ovalid_q;
  logic              overflow_q;
  logic [7:0]        byte_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      wcnt       <= '0;
      bcnt       <= '0;
      digest_q   <= '0;
      dvalid_q   <= 1'b0;
      ovalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      // A word on the flush edge is discarded silently; overflow is left untouched.
      state    <= COLLECT;
      wcnt     <= '0;
      bcnt     <= '0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            digest_q <= {digest_q[DIG_W-WORD_W-1:0], bus.in_word};
            if (wcnt == WCNT_LAST) begin
              state    <= DRAIN;
              wcnt     <= '0;
              bcnt     <= '0;
              dvalid_q <= 1'b1;
              ovalid_q <= 1'b1;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.in_valid) overflow_q <= 1'b1;
          if (ovalid_q && bus.out_ready) begin
            if (bcnt == BCNT_LAST) begin
              state    <= COLLECT;
              bcnt     <= '0;
              dvalid_q <= 1'b0;
              ovalid_q <= 1'b0;
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Byte mux driven only by registered digest and byte count.
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (bcnt == BCNT_W'(i)) byte_sel = digest_q[DIG_W-1-8*i -: 8];
    end
  end

  assign bus.digest       = digest_q;
  assign bus.digest_valid = dvalid_q;
  assign bus.out_valid    = ovalid_q;
  assign bus.out_byte     = byte_sel;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_sha2_digest_collector.sv
// tb/tb_sha2_digest_collector.sv - scoreboard bench for sha2_digest_collector
module tb_sha2_digest_collector;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha2_digest_collector_if #(.WORD_W(32), .WORDS(8)) bus ();
  sha2_digest_collector #(.WORD_W(32), .WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [255:0] VEC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [31:0] vec [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];
  int hold_errs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Collects up to nbytes transferred bytes into rcv_q; toggle gives out_ready 1010...
  task automatic drain_collect(input int nbytes, input bit toggle, input int stall_at,
                               output int cycles, output bit timed_out);
    int ph;
    int stall_left;
    bit held;
    logic [7:0] prev;
    rcv_q.delete();
    hold_errs = 0; cycles = 0; ph = 0; stall_left = 5; held = 0; timed_out = 0; prev = '0;
    while (rcv_q.size() < nbytes) begin
      if (cycles >= 400) begin timed_out = 1; break; end
      if (held && bus.out_byte !== prev) hold_errs++;
      bus.out_ready = toggle ? (ph % 2 == 0) : 1'b1;
      if (stall_at >= 0 && rcv_q.size() == stall_at && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end
      ph++;
      held = bus.out_valid && !bus.out_ready;
      prev = bus.out_byte;
      if (bus.out_valid && bus.out_ready) rcv_q.push_back(bus.out_byte);
      tick();
      cycles++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.digest, bus.digest_valid, bus.out_valid, bus.out_byte, bus.overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got dv=%b ov=%b byte=%h of=%b digest=%h required all zero",
               bus.digest_valid, bus.out_valid, bus.out_byte, bus.overflow, bus.digest);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int cyc;
    bit to;
    for (int i = 0; i < 8; i++) send_word(vec[i]);
    drain_collect(3, 0, -1, cyc, to);
    send_word(32'h01020304);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_overflow: got %b required 1", bus.overflow);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus.digest, bus.digest_valid, bus.out_valid, bus.out_byte, bus.overflow} !== '0) begin
      failures++;
      $display("FAIL async_reset: got dv=%b ov=%b byte=%h of=%b required all zero before edge",
               bus.digest_valid, bus.out_valid, bus.out_byte, bus.overflow);
    end
    #1 rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_consecutive();
    int cyc;
    bit to;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      bus.in_valid = 1'b1;
      bus.in_word  = vec[i];
      tick();
      if (i == 6) begin
        checks++;
        if (bus.digest_valid !== 1'b0) begin
          failures++;
          $display("FAIL consec_early_dv: got %b required 0 after 7 words", bus.digest_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.digest_valid !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL consec_latency: got dv=%b ov=%b required 1 1", bus.digest_valid, bus.out_valid);
    end
    checks++;
    if (bus.digest !== VEC_DIG) begin
      failures++;
      $display("FAIL consec_digest: got %h required %h", bus.digest, VEC_DIG);
    end
    drain_collect(32, 0, -1, cyc, to);
    checks++;
    if (to || cyc !== 32) begin
      failures++;
      $display("FAIL consec_cycles: got %0d cycles timeout=%0d required 32", cyc, to);
    end
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL consec_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
    checks++;
    if (bus.digest_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.digest !== VEC_DIG) begin
      failures++;
      $display("FAIL consec_end: got dv=%b ov=%b digest=%h required 0 0 held digest",
               bus.digest_valid, bus.out_valid, bus.digest);
    end
  endtask

  task automatic test_gaps();
    int cyc;
    bit to;
    int early;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      send_word(vec[i]);
      if (i < 7) begin
        if (bus.digest_valid !== 1'b0) early++;
        for (int g = 0; g < 3; g++) begin
          tick();
          if (bus.digest_valid !== 1'b0) early++;
        end
      end
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL gaps_early_dv: got %0d early cycles required 0", early);
    end
    checks++;
    if (bus.digest_valid !== 1'b1 || bus.digest !== VEC_DIG) begin
      failures++;
      $display("FAIL gaps_digest: got dv=%b %h required 1 %h", bus.digest_valid, bus.digest, VEC_DIG);
    end
    drain_collect(32, 0, -1, cyc, to);
    checks++;
    if (to || rcv_q.size() != 32) begin
      failures++;
      $display("FAIL gaps_count: got %0d bytes required 32", rcv_q.size());
    end
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL gaps_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit to;
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      send_word(vec[i]);
    end
    drain_collect(32, 1, 7, cyc, to);
    checks++;
    if (to || rcv_q.size() != 32) begin
      failures++;
      $display("FAIL bp_count: got %0d bytes required 32", rcv_q.size());
    end
    checks++;
    if (hold_errs != 0) begin
      failures++;
      $display("FAIL bp_hold: got %0d byte changes while stalled required 0", hold_errs);
    end
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL bp_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: got %0d leftover ov=%b required 0 0", exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    bit to;
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      send_word(vec[i]);
    end
    for (int i = 0; i < 3; i++) send_word(32'hdead0000 + i);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: got %b required 1", bus.overflow);
    end
    drain_collect(32, 0, -1, cyc, to);
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL ovf_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      push_word(32'h0);
      send_word(32'h0);
    end
    checks++;
    if (bus.digest !== 256'h0 || bus.digest_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_zero: got dv=%b of=%b digest=%h required 1 1 zero",
               bus.digest_valid, bus.overflow, bus.digest);
    end
    drain_collect(32, 0, -1, cyc, to);
    checks++;
    if (to || rcv_q.size() != 32) begin
      failures++;
      $display("FAIL ovf_zero_count: got %0d bytes required 32", rcv_q.size());
    end
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL ovf_zero_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
  endtask

  task automatic test_flush();
    int cyc;
    bit to;
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send_word(vec[i]);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_word = 32'h12345678;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.digest_valid !== 1'b0 || bus.digest !== 256'h0) begin
      failures++;
      $display("FAIL flush_partial: got of=%b dv=%b digest=%h required 0 0 zero",
               bus.overflow, bus.digest_valid, bus.digest);
    end
    for (int i = 0; i < 8; i++) begin
      push_word(32'hffffffff);
      send_word(32'hffffffff);
    end
    checks++;
    if (bus.digest !== {256{1'b1}} || bus.digest_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL flush_ones: got dv=%b of=%b digest=%h required 1 0 all-ones",
               bus.digest_valid, bus.overflow, bus.digest);
    end
    drain_collect(32, 0, -1, cyc, to);
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL flush_ones_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      send_word(vec[i]);
    end
    drain_collect(5, 0, -1, cyc, to);
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL flush_part_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
    exp_q.delete();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.digest_valid !== 1'b0 || bus.digest !== 256'h0) begin
      failures++;
      $display("FAIL flush_drain: got ov=%b dv=%b digest=%h required 0 0 zero",
               bus.out_valid, bus.digest_valid, bus.digest);
    end
    for (int i = 0; i < 8; i++) begin
      push_word(vec[i]);
      send_word(vec[i]);
    end
    checks++;
    if (bus.digest !== VEC_DIG || bus.digest_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_recover: got dv=%b %h required 1 %h", bus.digest_valid, bus.digest, VEC_DIG);
    end
    drain_collect(32, 0, -1, cyc, to);
    checks++;
    if (to || rcv_q.size() != 32) begin
      failures++;
      $display("FAIL flush_recover_count: got %0d bytes required 32", rcv_q.size());
    end
    for (int i = 0; i < rcv_q.size(); i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rcv_q[i] !== e) begin
        failures++;
        $display("FAIL flush_recover_byte%0d: got %h required %h", i, rcv_q[i], e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_async_reset();
    test_consecutive();
    test_gaps();
    test_backpressure();
    test_overflow();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
